// File: rtl/alsu_gen_if.sv
// alsu_gen_if: transaction bus between the stimulus/register front end and
// the alsu_gen datapath.
//   master: the front end; drives the request (in_valid, operands, flags,
//           opcode) and observes in_ready, out_valid, out and leds.
//   slave : the ALSU; accepts the request and returns result and LED bank.
interface alsu_gen_if #(
  parameter int WIDTH = 3,
  parameter int LED_W = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               cin;
  logic               serial_in;
  logic               red_op_A;
  logic               red_op_B;
  logic [2:0]         opcode;
  logic               bypass_A;
  logic               bypass_B;
  logic               direction;
  logic               out_valid;
  logic [2*WIDTH-1:0] out;
  logic [LED_W-1:0]   leds;

  modport master (
    output in_valid, A, B, cin, serial_in, red_op_A, red_op_B, opcode,
           bypass_A, bypass_B, direction,
    input  in_ready, out_valid, out, leds
  );

  modport slave (
    input  in_valid, A, B, cin, serial_in, red_op_A, red_op_B, opcode,
           bypass_A, bypass_B, direction,
    output in_ready, out_valid, out, leds
  );
endinterface

// File: rtl/alsu_gen.sv
// alsu_gen: handshaked, parametrised ALSU with an iterative signed multiplier.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - alsu_gen_if slave: in_valid/in_ready request handshake, operands
//          A/B, cin, serial_in, reduction and bypass flags, opcode, direction;
//          out_valid strobe, held 2*WIDTH-bit signed out, LED_W-bit leds.
// Flow: IDLE captures a request, EVAL either finishes it or hands a multiply
// to MUL, which runs one shift-add step per cycle for WIDTH cycles.
module alsu_gen #(
  parameter int WIDTH          = 3,
  parameter     INPUT_PRIORITY = "A",
  parameter     FULL_ADDER     = "ON",
  parameter int LED_W          = 16
) (
  input logic       clk,
  input logic       rst,
  alsu_gen_if.slave bus
);
  localparam int RW      = 2 * WIDTH;
  localparam int CW      = $clog2(WIDTH) + 1;
  localparam bit PRI_B   = (INPUT_PRIORITY == "B");
  localparam bit USE_CIN = (FULL_ADDER == "ON");

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q, b_q;
  logic             cin_q, sin_q, red_a_q, red_b_q, byp_a_q, byp_b_q, dir_q;
  logic [2:0]       op_q;
  logic [RW-1:0]    out_q;
  logic             out_valid_q;
  logic [LED_W-1:0] leds_q;

  logic [RW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [RW-1:0]    acc_q;
  logic             neg_q;
  logic [CW-1:0]    count_q;

  logic [RW-1:0]    a_ext, b_ext, eval_res, acc_next, mul_res;
  logic [WIDTH-1:0] red_src, a_mag, b_mag;
  logic             invalid, is_mul, led_toggle;

  assign a_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign b_ext = {{WIDTH{b_q[WIDTH-1]}}, b_q};

  assign invalid = ((red_a_q | red_b_q) & (op_q[1] | op_q[2])) | (op_q[1] & op_q[2]);
  assign is_mul  = ~byp_a_q & ~byp_b_q & ~invalid & (op_q == 3'd3);
  // Only an unbypassed invalid request flips the LED bank; anything else clears it.
  assign led_toggle = invalid & ~byp_a_q & ~byp_b_q;

  // When both reduction flags are set the priority operand is reduced.
  assign red_src = (red_a_q & red_b_q) ? (PRI_B ? b_q : a_q)
                                       : (red_a_q ? a_q : b_q);

  // The multiplier works on magnitudes; -2^(WIDTH-1) negates to itself, which
  // read as unsigned is exactly the right magnitude.
  assign a_mag = a_q[WIDTH-1] ? -a_q : a_q;
  assign b_mag = b_q[WIDTH-1] ? -b_q : b_q;

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_res  = neg_q ? -acc_next : acc_next;

  // Single-cycle result for every non-multiply request, resolved in priority
  // order: bypass, invalid, then opcode. SHIFT/ROTATE act on the held out.
  always_comb begin
    eval_res = '0;
    if (byp_a_q && byp_b_q) begin
      eval_res = PRI_B ? b_ext : a_ext;
    end else if (byp_a_q) begin
      eval_res = a_ext;
    end else if (byp_b_q) begin
      eval_res = b_ext;
    end else if (!invalid) begin
      case (op_q)
        3'd0: eval_res = (red_a_q | red_b_q) ? {{(RW-1){1'b0}}, |red_src} : (a_ext | b_ext);
        3'd1: eval_res = (red_a_q | red_b_q) ? {{(RW-1){1'b0}}, ^red_src} : (a_ext ^ b_ext);
        3'd2: eval_res = a_ext + b_ext + {{(RW-1){1'b0}}, cin_q & USE_CIN};
        3'd4: eval_res = dir_q ? {out_q[RW-2:0], sin_q} : {sin_q, out_q[RW-1:1]};
        3'd5: eval_res = dir_q ? {out_q[RW-2:0], out_q[RW-1]} : {out_q[0], out_q[RW-1:1]};
        default: eval_res = out_q;
      endcase
    end
  end

  // Control FSM, request capture, shift-add engine and result/LED registers.
  // out_valid defaults low so every completion is a one-cycle strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      sin_q       <= 1'b0;
      red_a_q     <= 1'b0;
      red_b_q     <= 1'b0;
      byp_a_q     <= 1'b0;
      byp_b_q     <= 1'b0;
      dir_q       <= 1'b0;
      op_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      leds_q      <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      neg_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            cin_q   <= bus.cin;
            sin_q   <= bus.serial_in;
            red_a_q <= bus.red_op_A;
            red_b_q <= bus.red_op_B;
            byp_a_q <= bus.bypass_A;
            byp_b_q <= bus.bypass_B;
            dir_q   <= bus.direction;
            op_q    <= bus.opcode;
            state   <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (is_mul) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_mag};
            mplier_q <= b_mag;
            neg_q    <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
            acc_q    <= '0;
            count_q  <= '0;
            state    <= S_MUL;
          end else begin
            out_q       <= eval_res;
            out_valid_q <= 1'b1;
            leds_q      <= led_toggle ? ~leds_q : '0;
            state       <= S_IDLE;
          end
        end
        S_MUL: begin
          acc_q    <= acc_next;
          mcand_q  <= {mcand_q[RW-2:0], 1'b0};
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + 1'b1;
          if (count_q == CW'(WIDTH - 1)) begin
            out_q       <= mul_res;
            out_valid_q <= 1'b1;
            leds_q      <= '0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.leds      = leds_q;
endmodule

// File: tb/tb_alsu_gen.sv
// tb_alsu_gen: directed bench for alsu_gen. Two instances share clock, reset
// and stimulus: dut_a uses the default parameters, dut_b uses
// INPUT_PRIORITY="B" and FULL_ADDER="OFF". Latency is counted in falling
// edges after the accept edge up to the one where out_valid is seen high.
module tb_alsu_gen;
  localparam int WIDTH = 3;
  localparam int LED_W = 16;

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   lat;
  int   busy;
  int   seen;

  alsu_gen_if #(.WIDTH(WIDTH), .LED_W(LED_W)) bus_a ();
  alsu_gen_if #(.WIDTH(WIDTH), .LED_W(LED_W)) bus_b ();

  alsu_gen #(.WIDTH(WIDTH), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .LED_W(LED_W))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));

  alsu_gen #(.WIDTH(WIDTH), .INPUT_PRIORITY("B"), .FULL_ADDER("OFF"), .LED_W(LED_W))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_inputs(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                            input logic c, input logic s, input logic ra, input logic rb,
                            input logic ba, input logic bb, input logic dir);
    bus_a.opcode = op;  bus_b.opcode = op;
    bus_a.A = a;        bus_b.A = a;
    bus_a.B = b;        bus_b.B = b;
    bus_a.cin = c;      bus_b.cin = c;
    bus_a.serial_in = s; bus_b.serial_in = s;
    bus_a.red_op_A = ra; bus_b.red_op_A = ra;
    bus_a.red_op_B = rb; bus_b.red_op_B = rb;
    bus_a.bypass_A = ba; bus_b.bypass_A = ba;
    bus_a.bypass_B = bb; bus_b.bypass_B = bb;
    bus_a.direction = dir; bus_b.direction = dir;
  endtask

  // Called on a falling edge: presents one request, waits for out_valid
  // (bounded) and checks the accept-to-out_valid latency.
  task automatic apply_stimulus(input string tag, input logic [2:0] op, input logic [2:0] a,
                                input logic [2:0] b, input logic c, input logic s,
                                input logic ra, input logic rb, input logic ba,
                                input logic bb, input logic dir, input int exp_lat);
    set_inputs(op, a, b, c, s, ra, rb, ba, bb, dir);
    bus_a.in_valid = 1'b1;
    bus_b.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
    lat  = 0;
    busy = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      lat++;
      if (!bus_a.in_ready) busy++;
      if (bus_a.out_valid) break;
    end
    check_output({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    rst = 1'b0;
    set_inputs(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_out", 64'(bus_a.out), 64'h0);
    check_output("reset_leds", 64'(bus_a.leds), 64'h0);
    check_output("reset_out_valid", 64'(bus_a.out_valid), 64'h0);
    check_output("reset_in_ready", 64'(bus_a.in_ready), 64'h1);
    rst = 1'b1;
    @(negedge clk);

    // ADD 3+3+1: carry honoured on dut_a, ignored on dut_b
    apply_stimulus("add_cin", 3'd2, 3'd3, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    check_output("add_cin_busy", 64'(busy), 64'd1);
    check_output("add_cin_out", 64'(bus_a.out), 64'h07);
    check_output("add_nocin_out", 64'(bus_b.out), 64'h06);
    check_output("add_cin_valid_b", 64'(bus_b.out_valid), 64'h1);
    @(negedge clk);
    check_output("strobe_low", 64'(bus_a.out_valid), 64'h0);
    check_output("out_held", 64'(bus_a.out), 64'h07);

    // Invalid opcode toggles leds, result 0
    apply_stimulus("op6", 3'd6, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    check_output("op6_out", 64'(bus_a.out), 64'h0);
    check_output("op6_leds", 64'(bus_a.leds), 64'hFFFF);

    // Both bypass: priority operand sign-extended, leds cleared
    apply_stimulus("byp", 3'd7, 3'b110, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2);
    check_output("byp_pri_a_out", 64'(bus_a.out), 64'h3E);
    check_output("byp_pri_b_out", 64'(bus_b.out), 64'h01);
    check_output("byp_leds_a", 64'(bus_a.leds), 64'h0);
    check_output("byp_leds_b", 64'(bus_b.leds), 64'h0);

    // Two invalids in a row: 0000 -> FFFF -> 0000
    apply_stimulus("op7", 3'd7, 3'd2, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    check_output("op7_leds", 64'(bus_a.leds), 64'hFFFF);
    apply_stimulus("op6b", 3'd6, 3'd2, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    check_output("op6b_leds", 64'(bus_a.leds), 64'h0);

    // Reduction flag with ADD is invalid
    apply_stimulus("red_add", 3'd2, 3'd1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    check_output("red_add_out", 64'(bus_a.out), 64'h0);
    check_output("red_add_leds", 64'(bus_a.leds), 64'hFFFF);

    // Valid OR clears leds
    apply_stimulus("or", 3'd0, 3'b001, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    check_output("or_out", 64'(bus_a.out), 64'h03);
    check_output("or_leds", 64'(bus_a.leds), 64'h0);

    // Signed multiplies including the -2^(WIDTH-1) magnitude
    apply_stimulus("mul_m4x3", 3'd3, 3'b100, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5);
    check_output("mul_m4x3_busy", 64'(busy), 64'd4);
    check_output("mul_m4x3_out", 64'(bus_a.out), 64'h34);
    check_output("mul_m4x3_out_b", 64'(bus_b.out), 64'h34);
    apply_stimulus("mul_m4xm4", 3'd3, 3'b100, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5);
    check_output("mul_m4xm4_out", 64'(bus_a.out), 64'h10);
    apply_stimulus("mul_3xm1", 3'd3, 3'b011, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5);
    check_output("mul_3xm1_out", 64'(bus_a.out), 64'h3D);

    // Shift left then rotate right on the held result
    apply_stimulus("add5", 3'd2, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    check_output("add5_out", 64'(bus_a.out), 64'h05);
    apply_stimulus("shl", 3'd4, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    check_output("shl_out", 64'(bus_a.out), 64'h0B);
    apply_stimulus("rotr", 3'd5, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    check_output("rotr_out", 64'(bus_a.out), 64'h25);

    // Asynchronous reset mid-run takes effect without a clock edge
    rst = 1'b0;
    #1;
    check_output("midrst_out", 64'(bus_a.out), 64'h0);
    check_output("midrst_in_ready", 64'(bus_a.in_ready), 64'h1);
    check_output("midrst_out_valid", 64'(bus_a.out_valid), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    apply_stimulus("add5b", 3'd2, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    check_output("add5b_out", 64'(bus_a.out), 64'h05);

    // Reset during the second MUL cycle aborts the multiply
    set_inputs(3'd3, 3'b100, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus_a.in_valid = 1'b1;
    bus_b.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("mulrst_out", 64'(bus_a.out), 64'h0);
    check_output("mulrst_in_ready", 64'(bus_a.in_ready), 64'h1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 1) rst = 1'b1;
      if (bus_a.out_valid) seen++;
    end
    check_output("mulrst_no_valid", 64'(seen), 64'd0);
    check_output("mulrst_out_after", 64'(bus_a.out), 64'h0);

    // First request after release has normal latency
    apply_stimulus("add111", 3'd2, 3'd1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    check_output("add111_out_a", 64'(bus_a.out), 64'h03);
    check_output("add111_out_b", 64'(bus_b.out), 64'h02);

    // Both reduction flags: priority operand reduced, single LSB result
    apply_stimulus("or_red2", 3'd0, 3'b000, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    check_output("or_red2_out_a", 64'(bus_a.out), 64'h00);
    check_output("or_red2_out_b", 64'(bus_b.out), 64'h01);

    // Bitwise XOR sign-extends
    apply_stimulus("xor", 3'd1, 3'b101, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    check_output("xor_out", 64'(bus_a.out), 64'h3E);

    // Most-negative ADD does not overflow at 2*WIDTH
    apply_stimulus("add_neg", 3'd2, 3'b100, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    check_output("add_neg_out_a", 64'(bus_a.out), 64'h39);
    check_output("add_neg_out_b", 64'(bus_b.out), 64'h38);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
